draw_image: RTL and testbench
=============================

# draw_image

Drawing stage directly upstream of the 64×64 image ROM in the VGA pixel pipeline. Takes the VGA timing bus and background colour, generates the ROM address `{dy[5:0], dx[5:0]}` for pixels inside a movable 64×64 window, and consumes the ROM's registered 12-bit colour. It overlays that colour, with an optional transparency key, onto the incoming stream. Timing signals are delayed to stay pixel-aligned with the ROM data, so downstream stages see a consistent bus.

## Interface
- `IMG_W`, 64, image width in pixels; power of two, ≤ 64
- `IMG_H`, 64, image height in pixels; power of two, ≤ 64
- `KEY_EN`, 1, 1 = ROM pixels equal to `KEY_RGB` are transparent
- `KEY_RGB`, 12'hF0F, transparency colour
- `clk`  in  1  pixel clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `hcount_in`, `vcount_in`  in  11  pixel position
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in`  in  1  timing
- `rgb_in`  in  12  background colour
- `xpos`, `ypos`  in  11  requested image top-left corner
- `rom_addr`  out  12  ROM address `{dy[5:0], dx[5:0]}`, registered
- `rom_rgb`  in  12  ROM data, valid one cycle after `rom_addr`
- `hcount_out`, `vcount_out`  out  11  delayed timing
- `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out`  out  1  delayed timing
- `rgb_out`  out  12  composited colour

## Operation
- **Position latch.**
  - `x_lat`/`y_lat` load `xpos`/`ypos` on the cycle a rising edge of `vblnk_in` is detected (previous 0, current 1).
  - The image never moves mid-frame.
  - Reset value of the latch is 0; the edge-detect register also resets to 0.
- **Window test (stage 1).**
  - `in_win = (hcount_in >= x_lat) && ({1'b0,hcount_in} < {1'b0,x_lat}+IMG_W)`, and the same for v against `y_lat` and `IMG_H`.
  - Comparisons use 12 bits, so a window near 2047 does not wrap.
  - `dx = hcount_in - x_lat` and `dy = vcount_in - y_lat`, truncated to 6 bits.
  - `rom_addr <= in_win ? {dy[5:0],dx[5:0]} : 12'h000`.
- **ROM access (stage 2).**
  - The ROM registers its data, so `rom_rgb` corresponds to the stage-1 address.
  - `in_win`, `rgb_in` and all timing signals are carried along a 2-deep delay line, so they align with `rom_rgb` at the stage-2 output.
- **Composite (stage 3, registered output):**
  - if `hblnk|vblnk` (delayed): `rgb_out` = 12'h000;
  - else if `in_win_d2` and not (`KEY_EN` and `rom_rgb == KEY_RGB`): `rgb_out` = `rom_rgb`;
  - else: `rgb_out` = `rgb_in_d2`.
- **Clipping.** Windows partly off-screen are clipped naturally; no special handling is required.
- **No FSM.** The block is a fixed 3-stage pipeline plus the latch/edge-detect state.

## Timing
- Latency is exactly 3 clocks from any `*_in` to the matching `*_out`, for every signal, including `rgb_out`.
- `rom_addr` is 1 clock after the inputs.
- Throughput is one pixel per clock, with no stalls and no handshake.
- Reset (async assert, sync release):
  - all outputs and pipeline registers = 0;
  - `rom_addr` = 0;
  - latch = 0.
- The first 3 post-reset output cycles carry the zeroed pipeline contents.
- Reset mid-frame clears the pipeline immediately. After release, output is valid 3 cycles later, and the latch holds (0,0) until the next vblank rising edge.
- Simultaneous `xpos` change and vblank edge: the value present on the edge cycle is captured.
- A `vblnk_in` held at 1 through reset release does not count as an edge.

## Structure
- Shared package `vga_pkg` holds:
  - `HCOUNT_W = 11`, `RGB_W = 12`, `ADDR_W = 12`;
  - a packed struct `vga_if_t` {vcount, vsync, vblnk, hcount, hsync, hblnk, rgb} for the timing bus.
- One sub-module: `delay`, parameterised by width and depth, registered with async active-low reset. It is used for the timing/rgb/in_win delay lines.
- The ROM stays outside the block and connects via `rom_addr`/`rom_rgb`.

## Test plan
- **Reset.** Drive `rst_n`=0 mid-line → all outputs 0 within the same cycle, and `rom_addr` = 12'h000.
- **Alignment.** Position (100,50), ROM model returning `addr` as its colour, pixel (110,53) → `rom_addr` = {6'd3,6'd10} = 12'h0CA one clock later; three clocks after the input, `rgb_out` = 12'h0CA and `hcount_out` = 110.
- **Transparency.** ROM returns 12'hF0F at an in-window pixel with `rgb_in` = 12'h123 → `rgb_out` = 12'h123. With `KEY_EN`=0 → `rgb_out` = 12'hF0F.
- **Frame latch.** Change `xpos` from 100 to 200 mid-frame → output unchanged until the next `vblnk_in` rise. The following frame draws its window at columns 200–263.
- **Edges and blanking.**
  - Window at x=2000 → columns ≥ 2000 are drawn, and there is no wrap to column 0.
  - Pixel (163,50) with x=100 (dx = 63, last column) → drawn.
  - Pixel (164,50) → background.
  - Any pixel with `hblnk_in` = 1 → `rgb_out` = 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA pixel-pipeline widths and the timing-bus record carried between stages.
package vga_pkg;
  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned RGB_W    = 12;
  localparam int unsigned ADDR_W   = 12;

  typedef struct packed {
    logic [HCOUNT_W-1:0] vcount;
    logic                vsync;
    logic                vblnk;
    logic [HCOUNT_W-1:0] hcount;
    logic                hsync;
    logic                hblnk;
    logic [RGB_W-1:0]    rgb;
  } vga_if_t;
endpackage

// File: rtl/draw_image_delay.sv
// Fixed-depth register delay line with asynchronous active-low clear.
module delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);
  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];
endmodule

// File: rtl/draw_image.sv
// Overlays a 64x64 ROM image at a frame-latched position onto the VGA stream;
// 3-cycle pipeline: address, ROM read, composite.
module draw_image
  import vga_pkg::*;
#(
  parameter int unsigned      IMG_W   = 64,
  parameter int unsigned      IMG_H   = 64,
  parameter bit               KEY_EN  = 1'b1,
  parameter logic [RGB_W-1:0] KEY_RGB = 12'hF0F
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [HCOUNT_W-1:0] vcount_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                hblnk_in,
  input  logic                vblnk_in,
  input  logic [RGB_W-1:0]    rgb_in,
  input  logic [HCOUNT_W-1:0] xpos,
  input  logic [HCOUNT_W-1:0] ypos,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [RGB_W-1:0]    rom_rgb,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [HCOUNT_W-1:0] vcount_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                hblnk_out,
  output logic                vblnk_out,
  output logic [RGB_W-1:0]    rgb_out
);
  localparam logic [HCOUNT_W:0] IMG_W_EXT = IMG_W[HCOUNT_W:0];
  localparam logic [HCOUNT_W:0] IMG_H_EXT = IMG_H[HCOUNT_W:0];

  logic [HCOUNT_W-1:0] x_lat_q, y_lat_q;
  logic                vblnk_prev_q, armed_q;
  logic                vblnk_rise;

  // armed_q blocks a vblnk held high across reset release from reading as an edge
  assign vblnk_rise = vblnk_in & ~vblnk_prev_q & armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_lat_q      <= '0;
      y_lat_q      <= '0;
      vblnk_prev_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      armed_q      <= 1'b1;
      vblnk_prev_q <= vblnk_in;
      if (vblnk_rise) begin
        x_lat_q <= xpos;
        y_lat_q <= ypos;
      end
    end
  end

  logic       h_in, v_in, in_win;
  logic [5:0] dx, dy;
  logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;

  assign h_in = (hcount_in >= x_lat_q) &&
                ({1'b0, hcount_in} < ({1'b0, x_lat_q} + IMG_W_EXT));
  assign v_in = (vcount_in >= y_lat_q) &&
                ({1'b0, vcount_in} < ({1'b0, y_lat_q} + IMG_H_EXT));
  assign in_win = h_in && v_in;
  assign dx = hcount_in[5:0] - x_lat_q[5:0];
  assign dy = vcount_in[5:0] - y_lat_q[5:0];
  assign rom_addr_d = in_win ? {dy, dx} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rom_addr_q <= '0;
    else        rom_addr_q <= rom_addr_d;
  end

  assign rom_addr = rom_addr_q;

  vga_if_t bus_in, bus_d2, bus_out_d, bus_out_q;
  logic    in_win_d2;

  assign bus_in = '{vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in,
                    hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                    rgb: rgb_in};

  delay #(
    .WIDTH ($bits(vga_if_t) + 1),
    .DEPTH (2)
  ) u_bus_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  ({in_win, bus_in}),
    .dout_o ({in_win_d2, bus_d2})
  );

  always_comb begin
    bus_out_d = bus_d2;
    if (bus_d2.hblnk || bus_d2.vblnk)
      bus_out_d.rgb = '0;
    else if (in_win_d2 && !(KEY_EN && (rom_rgb == KEY_RGB)))
      bus_out_d.rgb = rom_rgb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus_out_q <= '0;
    else        bus_out_q <= bus_out_d;
  end

  assign hcount_out = bus_out_q.hcount;
  assign vcount_out = bus_out_q.vcount;
  assign hsync_out  = bus_out_q.hsync;
  assign vsync_out  = bus_out_q.vsync;
  assign hblnk_out  = bus_out_q.hblnk;
  assign vblnk_out  = bus_out_q.vblnk;
  assign rgb_out    = bus_out_q.rgb;
endmodule

// File: tb/tb_draw_image.sv
// Directed bench for draw_image: two instances (key on / key off) with registered ROM models.
module tb_draw_image;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0, xpos = '0, ypos = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b1, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;

  logic [11:0] rom_addr, rom_rgb = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  logic [11:0] rom_addr2, rom_rgb2 = '0;
  logic [10:0] hcount_out2, vcount_out2;
  logic        hsync_out2, vsync_out2, hblnk_out2, vblnk_out2;
  logic [11:0] rgb_out2;

  logic        rom_force = 1'b0;
  logic [11:0] rom_force_val = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_rgb  <= rom_force ? rom_force_val : rom_addr;
    rom_rgb2 <= rom_force ? rom_force_val : rom_addr2;
  end

  draw_image #(.IMG_W(64), .IMG_H(64), .KEY_EN(1'b1), .KEY_RGB(12'hF0F)) dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  draw_image #(.IMG_W(64), .IMG_H(64), .KEY_EN(1'b0), .KEY_RGB(12'hF0F)) dut_nokey (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .rom_addr(rom_addr2), .rom_rgb(rom_rgb2),
    .hcount_out(hcount_out2), .vcount_out(vcount_out2),
    .hsync_out(hsync_out2), .vsync_out(vsync_out2), .hblnk_out(hblnk_out2), .vblnk_out(vblnk_out2),
    .rgb_out(rgb_out2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic [10:0] h, input logic [10:0] v, input logic hb,
                    input logic [11:0] rgb);
    hcount_in = h;
    vcount_in = v;
    hblnk_in  = hb;
    rgb_in    = rgb;
    tick();
  endtask

  task automatic fill;
    px(11'd0, 11'd0, 1'b1, 12'h000);
  endtask

  task automatic frame_start(input logic [10:0] x, input logic [10:0] y);
    xpos = x;
    ypos = y;
    vblnk_in = 1'b0;
    px(11'd0, 11'd600, 1'b1, 12'h000);
    vblnk_in = 1'b1;
    px(11'd0, 11'd601, 1'b1, 12'h000);
    vblnk_in = 1'b0;
    px(11'd0, 11'd602, 1'b1, 12'h000);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    vblnk_in = 1'b1;
    xpos = 11'd100;
    ypos = 11'd50;
    tick();
    tick();
    checks++;
    if (rgb_out !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp %h", rgb_out, 12'h000); end
    checks++;
    if (rom_addr !== 12'h000) begin errors++; $display("FAIL reset_addr got %h exp %h", rom_addr, 12'h000); end
    // release with vblnk held high: must not latch (100,50)
    rst_n = 1'b1;
    tick();
    tick();
    vblnk_in = 1'b0;
    px(11'd10, 11'd5, 1'b0, 12'h321);
    checks++;
    if (rom_addr !== 12'h14A) begin errors++; $display("FAIL post_reset_addr got %h exp %h", rom_addr, 12'h14A); end
    px(11'd11, 11'd5, 1'b0, 12'h321);
    px(11'd12, 11'd5, 1'b0, 12'h321);
    checks++;
    if (rgb_out !== 12'h14A) begin errors++; $display("FAIL post_reset_rgb got %h exp %h", rgb_out, 12'h14A); end
    checks++;
    if (hcount_out !== 11'd10) begin errors++; $display("FAIL post_reset_hcount got %0d exp %0d", hcount_out, 10); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rgb_out !== 12'h000) begin errors++; $display("FAIL midline_reset_rgb got %h exp %h", rgb_out, 12'h000); end
    checks++;
    if (hcount_out !== 11'd0) begin errors++; $display("FAIL midline_reset_hcount got %0d exp %0d", hcount_out, 0); end
    checks++;
    if (rom_addr !== 12'h000) begin errors++; $display("FAIL midline_reset_addr got %h exp %h", rom_addr, 12'h000); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_alignment;
    frame_start(11'd100, 11'd50);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    px(11'd110, 11'd53, 1'b0, 12'h555);
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    checks++;
    if (rom_addr !== 12'h0CA) begin errors++; $display("FAIL align_addr got %h exp %h", rom_addr, 12'h0CA); end
    fill();
    checks++;
    if (rgb_out === 12'h0CA) begin errors++; $display("FAIL align_early got %h exp not %h", rgb_out, 12'h0CA); end
    fill();
    checks++;
    if (rgb_out !== 12'h0CA) begin errors++; $display("FAIL align_rgb got %h exp %h", rgb_out, 12'h0CA); end
    checks++;
    if (hcount_out !== 11'd110) begin errors++; $display("FAIL align_hcount got %0d exp %0d", hcount_out, 110); end
    checks++;
    if (vcount_out !== 11'd53) begin errors++; $display("FAIL align_vcount got %0d exp %0d", vcount_out, 53); end
    checks++;
    if ({hsync_out, vsync_out} !== 2'b11) begin errors++; $display("FAIL align_sync got %b exp %b", {hsync_out, vsync_out}, 2'b11); end
  endtask

  task automatic test_transparency;
    frame_start(11'd100, 11'd50);
    rom_force = 1'b1;
    rom_force_val = 12'hF0F;
    px(11'd120, 11'd60, 1'b0, 12'h123);
    fill();
    fill();
    checks++;
    if (rgb_out !== 12'h123) begin errors++; $display("FAIL key_on got %h exp %h", rgb_out, 12'h123); end
    checks++;
    if (rgb_out2 !== 12'hF0F) begin errors++; $display("FAIL key_off got %h exp %h", rgb_out2, 12'hF0F); end
    rom_force_val = 12'hABC;
    px(11'd120, 11'd60, 1'b0, 12'h123);
    fill();
    fill();
    checks++;
    if (rgb_out !== 12'hABC) begin errors++; $display("FAIL key_nonkey got %h exp %h", rgb_out, 12'hABC); end
    rom_force = 1'b0;
  endtask

  task automatic test_frame_latch;
    frame_start(11'd100, 11'd50);
    xpos = 11'd200;
    px(11'd110, 11'd53, 1'b0, 12'h456);
    fill();
    fill();
    checks++;
    if (rgb_out !== 12'h0CA) begin errors++; $display("FAIL latch_hold_old got %h exp %h", rgb_out, 12'h0CA); end
    px(11'd210, 11'd53, 1'b0, 12'h456);
    fill();
    fill();
    checks++;
    if (rgb_out !== 12'h456) begin errors++; $display("FAIL latch_hold_new got %h exp %h", rgb_out, 12'h456); end
    frame_start(11'd200, 11'd50);
    px(11'd200, 11'd53, 1'b0, 12'h456);
    px(11'd263, 11'd53, 1'b0, 12'h456);
    px(11'd264, 11'd53, 1'b0, 12'h456);
    checks++;
    if (rgb_out !== 12'h0C0) begin errors++; $display("FAIL latch_col200 got %h exp %h", rgb_out, 12'h0C0); end
    px(11'd110, 11'd53, 1'b0, 12'h456);
    checks++;
    if (rgb_out !== 12'h0FF) begin errors++; $display("FAIL latch_col263 got %h exp %h", rgb_out, 12'h0FF); end
    fill();
    checks++;
    if (rgb_out !== 12'h456) begin errors++; $display("FAIL latch_col264 got %h exp %h", rgb_out, 12'h456); end
    fill();
    checks++;
    if (rgb_out !== 12'h456) begin errors++; $display("FAIL latch_old_col got %h exp %h", rgb_out, 12'h456); end
  endtask

  task automatic test_edges;
    frame_start(11'd100, 11'd50);
    px(11'd163, 11'd50, 1'b0, 12'h789);
    px(11'd164, 11'd50, 1'b0, 12'h789);
    px(11'd120, 11'd55, 1'b1, 12'h789);
    checks++;
    if (rgb_out !== 12'h03F) begin errors++; $display("FAIL edge_last_col got %h exp %h", rgb_out, 12'h03F); end
    fill();
    checks++;
    if (rgb_out !== 12'h789) begin errors++; $display("FAIL edge_past_col got %h exp %h", rgb_out, 12'h789); end
    fill();
    checks++;
    if (rgb_out !== 12'h000) begin errors++; $display("FAIL edge_hblank got %h exp %h", rgb_out, 12'h000); end
    checks++;
    if (hblnk_out !== 1'b1) begin errors++; $display("FAIL edge_hblnk_out got %b exp %b", hblnk_out, 1'b1); end
    frame_start(11'd2000, 11'd50);
    px(11'd2000, 11'd50, 1'b0, 12'h777);
    px(11'd2047, 11'd50, 1'b0, 12'h777);
    px(11'd0, 11'd50, 1'b0, 12'h777);
    checks++;
    if (rgb_out !== 12'h000) begin errors++; $display("FAIL edge_x2000 got %h exp %h", rgb_out, 12'h000); end
    fill();
    checks++;
    if (rgb_out !== 12'h02F) begin errors++; $display("FAIL edge_x2047 got %h exp %h", rgb_out, 12'h02F); end
    fill();
    checks++;
    if (rgb_out !== 12'h777) begin errors++; $display("FAIL edge_nowrap got %h exp %h", rgb_out, 12'h777); end
  endtask

  initial begin
    test_reset();
    test_alignment();
    test_transparency();
    test_frame_latch();
    test_edges();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
